// File: rtl/addressing_pixel.sv
// rtl/addressing_pixel.sv - QVGA RGB444 frame-buffer store addressed by {row, column}
//
// Purpose:
//   Single-port frame buffer holding one 320x240 frame of 12-bit pixels.
//   The {row, col} address is folded into a linear RAM index with shifts and adds.
//   Out-of-range coordinates are never written, and reads from them return 0.
//   The RAM array has no reset, so its contents survive a reset pulse.
//
// Ports:
//   i_CLK    in   1       system clock, rising edge
//   i_RSTn   in   1       asynchronous active-high reset (name kept from codebase)
//   i_DATA   in   DATA_W  pixel to write
//   i_WRITE  in   1       write strobe, level-sensitive
//   i_READ   in   1       read strobe, level-sensitive
//   ADDRESS  in   17      [16:9] row, [8:0] column
//   o_DATA   out  DATA_W  registered read data, one-cycle latency

module addressing_pixel #(
  parameter int H_PIX  = 320,
  parameter int V_PIX  = 240,
  parameter int DATA_W = 12
) (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_WRITE,
  input  logic              i_READ,
  input  logic [16:0]       ADDRESS,
  output logic [DATA_W-1:0] o_DATA
);

  localparam int DEPTH = H_PIX * V_PIX;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [7:0]        row;
  logic [8:0]        col;
  logic              in_range;
  logic [16:0]       lin;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] o_data_q;

  assign row = ADDRESS[16:9];
  assign col = ADDRESS[8:0];

  assign in_range = ({24'd0, row} < V_PIX[31:0]) && ({23'd0, col} < H_PIX[31:0]);

  // row*320 + col as (row<<8) + (row<<6) + col. Rows 0..239 keep this within
  // 17 bits. Out-of-range coordinates are blocked by in_range, so no wrapped
  // index ever reaches the RAM.
  assign lin = {1'b0, row, 8'd0} + {3'd0, row, 6'd0} + {8'd0, col};

  // Unknown strobe values do not trigger an access.
  assign wr_en = (i_WRITE === 1'b1) && !i_RSTn;
  assign rd_en = (i_READ === 1'b1);

  // RAM write port. The array has no reset so it can map onto block RAM.
  always_ff @(posedge i_CLK) begin
    if (wr_en && in_range) begin
      mem[lin] <= i_DATA;
    end
  end

  // Registered read. The nonblocking write above makes a same-edge read
  // return the old word (read-first).
  always_ff @(posedge i_CLK or posedge i_RSTn) begin
    if (i_RSTn) begin
      o_data_q <= '0;
    end else if (rd_en) begin
      o_data_q <= in_range ? mem[lin] : '0;
    end
  end

  assign o_DATA = o_data_q;

endmodule

// File: tb/tb_addressing_pixel.sv
// tb/tb_addressing_pixel.sv - self-checking bench for addressing_pixel

module tb_addressing_pixel;

  logic        clk;
  logic        rst;
  logic [11:0] din;
  logic        wr;
  logic        rd;
  logic [16:0] addr;
  logic [11:0] dout;

  int checks;
  int errors;

  // Reference model: sparse frame keyed by row*320+col.
  logic [11:0] model [int];
  logic [11:0] exp_data;
  bit          exp_known;

  addressing_pixel dut (
    .i_CLK   (clk),
    .i_RSTn  (rst),
    .i_DATA  (din),
    .i_WRITE (wr),
    .i_READ  (rd),
    .ADDRESS (addr),
    .o_DATA  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    if (exp_known) begin
      checks++;
      assert (dout === exp_data)
      else begin
        errors++;
        $error("FAIL %s: o_DATA=%h expected %h", tag, dout, exp_data);
      end
    end
  endtask

  // One clock edge of access, with the result checked on the following falling edge.
  task automatic step(input bit w, input bit r, input int row_n, input int col_n,
                      input logic [11:0] d, input string tag);
    bit inr;
    int l;
    logic [7:0] rb;
    logic [8:0] cb;
    rb   = row_n[7:0];
    cb   = col_n[8:0];
    addr = {rb, cb};
    din  = d;
    wr   = w;
    rd   = r;
    @(posedge clk);
    inr = (row_n < 240) && (col_n < 320);
    l   = row_n * 320 + col_n;
    if (r) begin
      if (!inr) begin
        exp_data  = 12'h000;
        exp_known = 1'b1;
      end else if (model.exists(l)) begin
        exp_data  = model[l];
        exp_known = 1'b1;
      end else begin
        exp_known = 1'b0;
      end
    end
    if (w && inr) model[l] = d;
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    check(tag);
  endtask

  initial begin
    int rr;
    int cc;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    wr        = 1'b0;
    rd        = 1'b0;
    din       = '0;
    addr      = '0;
    exp_data  = 12'h000;
    exp_known = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_hold");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_reset_idle");

    // Write row 0 with data = col, then read it back.
    for (int c = 0; c < 240; c++) step(1'b1, 1'b0, 0, c, c[11:0], "row_write");
    for (int c = 0; c < 240; c++) step(1'b0, 1'b1, 0, c, 12'h000, "row_read");

    // Corners and aliasing.
    step(1'b1, 1'b0, 1, 0, 12'h010, "seed_1_0");
    step(1'b1, 1'b0, 0, 0, 12'hABC, "wr_0_0");
    step(1'b1, 1'b0, 239, 319, 12'h123, "wr_239_319");
    step(1'b0, 1'b1, 0, 0, 12'h000, "rd_0_0");
    step(1'b0, 1'b1, 239, 319, 12'h000, "rd_239_319");

    // Out-of-range writes are ignored and out-of-range reads return 0.
    step(1'b1, 1'b0, 0, 320, 12'hFFF, "wr_oor_col");
    step(1'b1, 1'b0, 240, 0, 12'hFFF, "wr_oor_row");
    step(1'b0, 1'b1, 1, 0, 12'h000, "rd_1_0_pre");
    step(1'b0, 1'b1, 0, 320, 12'h000, "rd_oor_col");
    step(1'b0, 1'b1, 1, 0, 12'h000, "rd_1_0");
    step(1'b0, 1'b1, 240, 0, 12'h000, "rd_oor_row");
    step(1'b0, 1'b1, 0, 0, 12'h000, "rd_0_0_after_oor");
    step(1'b0, 1'b1, 255, 511, 12'h000, "rd_oor_max");

    // Read-first collision.
    step(1'b1, 1'b0, 5, 5, 12'h111, "wr_5_5");
    step(1'b1, 1'b1, 5, 5, 12'h222, "collide_5_5");
    step(1'b0, 1'b1, 5, 5, 12'h000, "rd_5_5_new");

    // A read with the strobe low leaves o_DATA unchanged.
    step(1'b0, 1'b0, 0, 0, 12'h000, "hold_no_read");

    // Contents are retained across reset, and o_DATA clears asynchronously.
    step(1'b1, 1'b0, 10, 10, 12'h5A5, "wr_10_10");
    step(1'b0, 1'b1, 239, 319, 12'h000, "rd_nonzero");
    #2 rst = 1'b1;
    #1;
    exp_data  = 12'h000;
    exp_known = 1'b1;
    check("async_reset_clear");
    @(negedge clk);
    rst = 1'b0;
    check("after_reset_pulse");
    step(1'b0, 1'b1, 10, 10, 12'h000, "rd_10_10_retained");

    // An access on an edge while reset is held is dropped.
    step(1'b1, 1'b0, 20, 20, 12'h444, "wr_20_20");
    addr = {8'd20, 9'd20};
    din  = 12'h999;
    wr   = 1'b1;
    rd   = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr  = 1'b0;
    rd  = 1'b0;
    rst = 1'b0;
    exp_data  = 12'h000;
    exp_known = 1'b1;
    check("reset_mid_access");
    step(1'b0, 1'b1, 20, 20, 12'h000, "rd_20_20_unchanged");

    // Randomized traffic over a small pool that includes out-of-range coordinates.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        step(1'b1, 1'b0, r, c, 12'($urandom), "pool_init");
    for (int i = 0; i < 400; i++) begin
      rr = $urandom_range(0, 5);
      cc = $urandom_range(0, 9);
      if (rr >= 4) rr = rr + 236;
      if (cc >= 8) cc = cc + 312;
      step(1'($urandom), 1'($urandom), rr, cc, 12'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
